// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - round-robin duty command scheduler for pwm_generator
// Duty changes only on period_tick, as an immediate step or a saturating ramp.
module pwm_duty_ctrl #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int IW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               period_tick,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_duty,
    input  logic [NREQ-1:0]    req_ramp,
    input  logic [DW-1:0]      step,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      duty_out,
    output logic               busy,
    output logic               done,
    output logic [IW-1:0]      owner
);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  duty_q, duty_d;
    logic [DW-1:0]  target_q, target_d;
    logic           mode_q, mode_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  rr_last_q, rr_last_d;

    logic           gnt_found;
    logic [IW-1:0]  gnt_idx;
    logic [IW-1:0]  cand_idx;
    logic [DW-1:0]  gnt_duty;
    logic           gnt_ramp;
    logic [DW-1:0]  step_eff;
    logic [DW:0]    up_sum;
    logic [DW:0]    dn_diff;
    logic [DW-1:0]  ramp_nxt;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IW'((int'(rr_last_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        gnt_duty = '0;
        gnt_ramp = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                gnt_duty = req_duty[i*DW +: DW];
                gnt_ramp = req_ramp[i];
            end
        end
    end

    // One extra bit catches carry/borrow so the ramp clamps at target, never wraps.
    always_comb begin
        step_eff = (step == '0) ? DW'(1) : step;
        up_sum   = {1'b0, duty_q} + {1'b0, step_eff};
        dn_diff  = {1'b0, duty_q} - {1'b0, step_eff};
        ramp_nxt = target_q;
        if (duty_q < target_q) begin
            if (!(up_sum[DW] || (up_sum[DW-1:0] >= target_q))) begin
                ramp_nxt = up_sum[DW-1:0];
            end
        end else if (duty_q > target_q) begin
            if (!(dn_diff[DW] || (dn_diff[DW-1:0] <= target_q))) begin
                ramp_nxt = dn_diff[DW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = target_q;
        mode_d    = mode_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        req_ready = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready = NREQ'(1) << gnt_idx;
                    target_d  = gnt_duty;
                    mode_d    = gnt_ramp;
                    owner_d   = gnt_idx;
                    rr_last_d = gnt_idx;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (period_tick) begin
                    if (!mode_q) begin
                        duty_d  = target_q;
                        state_d = DONE;
                    end else begin
                        duty_d = ramp_nxt;
                        if (ramp_nxt == target_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            target_q  <= '0;
            mode_q    <= 1'b0;
            owner_q   <= '0;
            rr_last_q <= IW'(NREQ - 1);
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            mode_q    <= mode_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign duty_out = duty_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - directed and randomized bench for pwm_duty_ctrl
// Expected values come from an integer reference of the duty/arbitration rules.
module tb_pwm_duty_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IW   = 2;

    logic               clk;
    logic               rst;
    logic               period_tick;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_duty;
    logic [NREQ-1:0]    req_ramp;
    logic [DW-1:0]      step;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      duty_out;
    logic               busy;
    logic               done;
    logic [IW-1:0]      owner;

    int checks;
    int passed;
    int m_duty;
    int m_rr_last;
    bit mutate_step;

    pwm_duty_ctrl #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .period_tick (period_tick),
        .req_valid   (req_valid),
        .req_duty    (req_duty),
        .req_ramp    (req_ramp),
        .step        (step),
        .req_ready   (req_ready),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done),
        .owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int model_next(input int cur, input int tgt, input int stp, input bit rmp);
        int s;
        if (!rmp) return tgt;
        s = (stp == 0) ? 1 : stp;
        if (cur < tgt) return (cur + s >= tgt) ? tgt : cur + s;
        if (cur > tgt) return (cur - s <= tgt) ? tgt : cur - s;
        return tgt;
    endfunction

    task automatic set_duty(input int idx, input int val);
        req_duty[idx*DW +: DW] = DW'(val);
    endtask

    // Issues one command from the current IDLE negedge and follows it to IDLE again.
    task automatic run_cmd(input logic [NREQ-1:0] vmask, input logic [NREQ-1:0] rmask,
                           input bit hold, input bit grant_tick, input int abort_after,
                           output int granted);
        int g;
        int tgt;
        int ticks;
        int n;
        bit rmp;
        bit fin;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_rr_last + k) % NREQ;
            if (g < 0 && vmask[c]) g = c;
        end
        granted     = g;
        req_valid   = vmask;
        req_ramp    = rmask;
        period_tick = grant_tick;
        #1;
        chk("grant_ready", 32'(req_ready), 32'(1) << g);
        chk("idle_busy", 32'(busy), 0);
        tgt = int'(req_duty[g*DW +: DW]);
        rmp = rmask[g];
        @(posedge clk);
        m_rr_last = g;
        @(negedge clk);
        period_tick = 1'b0;
        if (!hold) req_valid = '0;
        chk("apply_busy", 32'(busy), 1);
        chk("apply_ready", 32'(req_ready), 0);
        chk("owner", 32'(owner), 32'(g));
        chk("grant_tick_ignored", 32'(duty_out), 32'(m_duty));
        fin   = 1'b0;
        ticks = 0;
        while (!fin && ticks < 300) begin
            if (abort_after != 0 && ticks == abort_after) return;
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                chk("no_tick_hold", 32'(duty_out), 32'(m_duty));
            end
            if (mutate_step && $urandom_range(0, 3) == 0) step = DW'($urandom_range(0, 9));
            period_tick = 1'b1;
            @(posedge clk);
            m_duty = model_next(m_duty, tgt, int'(step), rmp);
            @(negedge clk);
            period_tick = 1'b0;
            ticks++;
            fin = (m_duty == tgt);
            chk("duty", 32'(duty_out), 32'(m_duty));
            chk("done", 32'(done), 32'(fin));
            chk("busy", 32'(busy), 32'(!fin));
        end
        if (!fin) chk("timeout", 0, 1);
        chk("done_ready", 32'(req_ready), 0);
        @(negedge clk);
        chk("idle_done_low", 32'(done), 0);
        chk("idle_busy_low", 32'(busy), 0);
    endtask

    initial begin
        int g;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] vm;
        checks = 0; passed = 0;
        mutate_step = 1'b0;
        rst = 1'b1; period_tick = 1'b0; req_valid = '0; req_duty = '0; req_ramp = '0; step = '0;
        m_duty = 0; m_rr_last = NREQ - 1;
        repeat (3) @(negedge clk);
        chk("rst_duty", 32'(duty_out), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_owner", 32'(owner), 0);
        rst = 1'b0;
        @(negedge clk);

        set_duty(0, 'h80);
        run_cmd(4'b0001, 4'b0000, 0, 0, 0, g);
        chk("imm_duty_80", 32'(duty_out), 'h80);
        chk("imm_owner_0", 32'(owner), 0);

        set_duty(1, 'h10);
        run_cmd(4'b0010, 4'b0000, 0, 0, 0, g);
        step = 8'h10; set_duty(2, 'h40);
        run_cmd(4'b0100, 4'b0100, 0, 0, 0, g);
        chk("ramp_up_end", 32'(duty_out), 'h40);

        set_duty(3, 'hF0);
        run_cmd(4'b1000, 4'b0000, 0, 0, 0, g);
        step = 8'h20; set_duty(0, 'hFF);
        run_cmd(4'b0001, 4'b0001, 0, 0, 0, g);
        chk("ramp_sat_ff", 32'(duty_out), 'hFF);

        set_duty(1, 'h40);
        run_cmd(4'b0010, 4'b0000, 0, 0, 0, g);
        set_duty(2, 'h05);
        run_cmd(4'b0100, 4'b0100, 0, 0, 0, g);
        chk("ramp_down_end", 32'(duty_out), 'h05);

        step = 8'h00; set_duty(3, 'h08);
        run_cmd(4'b1000, 4'b1000, 0, 0, 0, g);
        set_duty(0, 'h08);
        run_cmd(4'b0001, 4'b0001, 0, 0, 0, g);
        chk("equal_target", 32'(duty_out), 'h08);

        set_duty(1, 'h33);
        run_cmd(4'b0010, 4'b0000, 0, 1, 0, g);

        step = 8'h01; set_duty(2, 'hFF);
        run_cmd(4'b0100, 4'b0100, 0, 0, 2, g);
        rst = 1'b1;
        #1;
        chk("midrst_duty", 32'(duty_out), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_owner", 32'(owner), 0);
        @(negedge clk);
        rst = 1'b0; period_tick = 1'b0;
        m_duty = 0; m_rr_last = NREQ - 1;
        @(negedge clk);

        for (int i = 0; i < NREQ; i++) set_duty(i, 16 * (i + 1));
        step = 8'h30;
        for (int i = 0; i < 5; i++) begin
            run_cmd(4'b1111, 4'b0101, 1, 0, 0, g);
            chk("rr_order", 32'(g), 32'(exp_order[i]));
        end
        req_valid = '0;

        mutate_step = 1'b1;
        for (int i = 0; i < 25; i++) begin
            for (int j = 0; j < NREQ; j++) set_duty(j, $urandom_range(0, 255));
            vm = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            step = DW'($urandom_range(0, 64));
            run_cmd(vm, NREQ'($urandom_range(0, (1 << NREQ) - 1)), $urandom_range(0, 1), $urandom_range(0, 1), 0, g);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Scheduler and sequencer for the shared `pwm_generator` duty input. Up to NREQ requesters submit duty commands over a valid/ready handshake, and a round-robin arbiter picks one command at a time. The block applies each command glitch-free: the duty value changes only on a PWM period boundary, either as a single immediate step or as a ramp of `step` per period. `duty_out` drives the `duty` port of `pwm_generator` directly.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- DW, 8: duty width; must match the `pwm_generator` duty width.
- IW, 2: owner index width; equals clog2(NREQ).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- period_tick  in  1  single-cycle pulse when the PWM counter wraps to 0.
- req_valid  in  NREQ  per-requester command valid.
- req_duty  in  NREQ*DW  target duty; requester i occupies bits [i*DW +: DW].
- req_ramp  in  NREQ  1 = ramp to target, 0 = immediate update.
- step  in  DW  ramp increment per period; 0 is treated as 1.
- req_ready  out  NREQ  one-hot grant; a command transfers when req_valid[i] & req_ready[i].
- duty_out  out  DW  registered duty to `pwm_generator`.
- busy  out  1  a command is accepted and not yet complete.
- done  out  1  one-cycle pulse when a command completes.
- owner  out  IW  index of the last granted requester.

## Operation
- Reset values: duty_out=0, req_ready=0, busy=0, done=0, owner=0, state=IDLE, rr_last=NREQ-1. With these values requester 0 has top priority after reset.
- States: IDLE, APPLY, DONE.
- IDLE:
  - req_ready is combinational: it is one-hot for the first requester with valid set, searching from rr_last+1 and wrapping modulo NREQ.
  - When any valid is set, the block latches target=req_duty[g] and mode=req_ramp[g], and sets owner=g and rr_last=g.
  - Next state is APPLY.
  - With no valid set, req_ready=0 and the block stays in IDLE.
- APPLY:
  - busy=1 and req_ready=0 in this state.
  - Cycles without period_tick leave duty_out unchanged.
  - On period_tick with mode=0: duty_out<=target, then go to DONE.
  - On period_tick with mode=1, where s = max(step,1):
    - If duty_out<target: nxt=duty_out+s, computed DW+1 bits wide. If nxt>=target or it carried out, nxt=target.
    - If duty_out>target: the subtraction duty_out-s is computed DW+1 bits wide. If it borrows or is <=target, nxt=target.
    - If duty_out==target: nxt=target.
    - duty_out<=nxt. Go to DONE when nxt==target, otherwise stay in APPLY.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. req_ready=0 in this state.
- Other requesters may hold valid indefinitely. Deasserting valid before ready is legal and has no effect.
- A requester's valid is never granted twice for one transfer.
- The step input is sampled live on each tick, so changing it mid-ramp takes effect on the next tick.
- Reset during APPLY or DONE drops the in-flight command and forces all reset values, including duty_out=0.

## Timing
- Grant: req_ready is high in the same cycle the IDLE state sees valid (cycle 0). busy=1 from cycle 1.
- A period_tick in cycle 0 (the grant cycle) is ignored; the first effective tick is sampled in APPLY.
- Update: a tick sampled at edge k gives the new duty_out at cycle k+1.
- Final update: done=1 and busy=0 at cycle k+1, IDLE at k+2, and the earliest next grant at k+2.
- Immediate command latency is grant → next tick → +1 cycle.
- Ramp length is ceil(|target-duty_out|/s) ticks, with a minimum of 1 tick. Equal values complete on the first tick.
- Consecutive ticks are allowed, though unrealistic. Each tick performs one step.
- Ticks arriving in DONE or IDLE are ignored.

## Test plan
- Reset, then req_valid=4'b0001, req_duty[0]=0x80, req_ramp=0:
  - req_ready=0001 in cycle 0.
  - After the next tick, duty_out=0x80 with done=1 in the same cycle.
  - owner=0.
- Ramp up from 0x10 to 0x40 with step=0x10:
  - duty_out goes 0x20, 0x30, 0x40 over three ticks; done on the third.
  - Ramp up from 0xF0 to 0xFF with step=0x20 saturates to 0xFF in one tick with no wrap.
- Ramp down from 0x40 to 0x05 with step=0x20:
  - duty_out goes 0x20, then 0x05; done on the second tick.
  - step=0 ramps by 1 per tick.
- All four valid, held high continuously:
  - Grants occur in order 0,1,2,3,0.
  - owner and req_ready track each grant.
  - No grant is issued while busy.
- Boundary cases:
  - A tick in the grant cycle does not update duty_out.
  - A target equal to the current duty gives done on the first tick with duty unchanged.
  - Asserting rst mid-ramp gives duty_out=0 and busy=0 immediately. Requester 0 is the first granted after release.
